// File: rtl/reg_file_buffered.sv
// rtl/reg_file_buffered.sv - 32x64 register file with a single pending-write buffer and read bypass
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset; clears the array and the pending write
//   RegWrite       write request, sampled at the rising edge
//   WriteRegister  destination index; writes to 31 are discarded
//   WriteData      write data
//   ReadRegister1  read port 1 index
//   ReadRegister2  read port 2 index
//   ReadData1      read port 1 data, combinational
//   ReadData2      read port 2 data, combinational
//   wr_pending     high while the pending-write register holds an uncommitted write

module reg_file_buffered (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RegWrite,
    input  logic [4:0]  WriteRegister,
    input  logic [63:0] WriteData,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2,
    output logic        wr_pending
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    // X31 has no storage; only entries 0..30 exist.
    logic [63:0] array [31];

    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic [63:0] pend_data;

    // 32-input view of the array feeding both read muxes, entry 31 tied to zero.
    logic [63:0] mux_in [32];

    logic capture;
    assign capture = RegWrite && (WriteRegister != ZERO_REG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_addr  <= 5'd0;
            pend_data  <= 64'd0;
        end else begin
            pend_valid <= capture;
            if (capture) begin
                pend_addr <= WriteRegister;
                pend_data <= WriteData;
            end
        end
    end

    // Commit uses the pending state from before this edge, so a new capture
    // and the previous write's commit share the same edge without a stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 31; i++) begin
                array[i] <= 64'd0;
            end
        end else begin
            for (int i = 0; i < 31; i++) begin
                if (pend_valid && (pend_addr == 5'(i))) begin
                    array[i] <= pend_data;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 31; i++) begin
            mux_in[i] = array[i];
        end
        mux_in[31] = 64'd0;
    end

    always_comb begin
        ReadData1 = mux_in[ReadRegister1];
        if (ReadRegister1 == ZERO_REG) begin
            ReadData1 = 64'd0;
        end else if (pend_valid && (pend_addr == ReadRegister1)) begin
            ReadData1 = pend_data;
        end
    end

    always_comb begin
        ReadData2 = mux_in[ReadRegister2];
        if (ReadRegister2 == ZERO_REG) begin
            ReadData2 = 64'd0;
        end else if (pend_valid && (pend_addr == ReadRegister2)) begin
            ReadData2 = pend_data;
        end
    end

    assign wr_pending = pend_valid;

endmodule

// File: doc/reg_file_buffered.md
# reg_file_buffered

32-entry × 64-bit register file with two combinational read ports and one write port buffered through a single pending-write register. It sits directly upstream of the 64-bit 32:1 read-port muxes: it holds the register array whose 32 entries feed each read mux, and it adds a bypass stage after each mux. X31 is the hardwired zero register.

## Interface
- Parameters: none. Data width is fixed at 64 and depth at 32.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- RegWrite  input  1  write request, sampled at the rising edge.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  write data.
- ReadRegister1  input  5  read port 1 index.
- ReadRegister2  input  5  read port 2 index.
- ReadData1  output  64  read port 1 data (combinational).
- ReadData2  output  64  read port 2 data (combinational).
- wr_pending  output  1  high while the pending-write register holds an uncommitted write.

## Operation
- State:
  - array[0..30], 64 bits each. X31 has no storage.
  - Pending register: pend_valid, pend_addr[4:0], pend_data[63:0].
- Capture: at a rising edge where RegWrite=1 and WriteRegister≠31:
  - pend_valid←1, pend_addr←WriteRegister, pend_data←WriteData.
- No capture: at a rising edge where RegWrite=0 or WriteRegister=31, pend_valid←0. Writes to X31 are silently discarded.
- Commit: at every rising edge where pend_valid=1 (evaluated before the update), array[pend_addr]←pend_data.
  - Commit and a new capture happen at the same edge, so writes stream back-to-back with no stall.
- Read path, per port K:
  - Each of the 32 mux inputs is array[i], except entry 31, which is tied to 64'h0.
  - ReadDataK = 0 if ReadRegisterK=31.
  - Otherwise ReadDataK = pend_data if pend_valid && pend_addr==ReadRegisterK.
  - Otherwise ReadDataK = the mux output.
- There is no combinational bypass from WriteData to ReadData; a write is never visible in the cycle it is presented.
- wr_pending = pend_valid.

## Timing
- Reset (reset_n=0, asynchronous, takes effect without a clock edge):
  - All array entries, pend_valid, pend_addr and pend_data clear to 0.
  - Consequently ReadData1=ReadData2=0 and wr_pending=0.
  - Reset asserted while a write is pending drops that write; the array does not hold it after reset.
- Read latency: 0 cycles, combinational from ReadRegisterK and state.
- Write visibility: a write presented in cycle N (captured at edge N/N+1) appears on read ports from cycle N+1, via the bypass. It lands in the array at edge N+1/N+2.
- Same-address back-to-back writes A then B (cycles N, N+1):
  - Cycle N+1 reads A.
  - Cycle N+2 reads B, because pending holds B while A commits.
  - The array ends with B.
- Different-address back-to-back writes: both are visible from the cycle after their own capture and both commit.
- Both read ports addressing the same register both take the bypass when it matches.
- A read of the pending address after that write commits returns the array value, which equals the former pend_data. There is no glitch across the commit edge.

## Test plan
- Reset: preload X5=64'hAAAA, assert reset_n=0 mid-cycle -> immediately ReadData1(X5)=0, wr_pending=0; release reset, all 32 registers read 0.
- Write/bypass/commit: write X3=64'h0123_4567_89AB_CDEF in cycle 0 ->
  - cycle 0: ReadData1(X3)=0.
  - cycle 1: 64'h0123_4567_89AB_CDEF with wr_pending=1.
  - cycle 2 onward: same value with wr_pending=0.
- X31: write X31=64'hFFFF_FFFF_FFFF_FFFF -> wr_pending stays 0; ReadData1/2(X31)=0 in every cycle.
- Same-address stream: write X7=1, X7=2, X7=3 on consecutive cycles, idle after -> ReadData2(X7) reads 0, 1, 2, 3, 3 on cycles 0-4.
- Dual port / different-address stream: write X1=64'h11, X2=64'h22 on cycles 0-1, with Read1=X1 and Read2=X2 -> cycle 2: ReadData1=64'h11, ReadData2=64'h22; then sweep Read1 over 0..31 and compare against a model.
- Reset mid-operation: write X9=64'h99 in cycle 0, assert reset_n=0 during cycle 1 -> ReadData(X9)=0 after reset release; no commit occurs.
